dma_bus_arbiter: RTL
====================

# dma_bus_arbiter

Bus arbiter between the CPU data-memory port and the DMA engine. It takes the DMA bus request (BR) and returns a registered bus grant (BG), but only at a safe point where no CPU data-memory access is in flight. While the bus is granted it stalls the CPU, and it forces the bus back if a grant overruns. It also converts the DMA end pulse into a level interrupt that the CPU clears with an acknowledge.

## Interface
- MAX_GRANT, default 12: largest legal number of consecutive BG-high cycles (one 12-word DMA burst).
- CNT_W, default 4: width of the grant-cycle counter; must hold MAX_GRANT.

- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- BR  in  1  bus request from DMA, level.
- dma_end  in  1  DMA completion, may be a pulse of one or more cycles.
- cpu_busy  in  1  CPU data-memory access in flight this cycle (read or write issued and not yet completed).
- cpu_irq_ack  in  1  CPU acknowledges the DMA interrupt, one-cycle pulse.
- BG  out  1  bus grant to DMA, registered.
- cpu_stall  out  1  CPU must not issue data-memory accesses, registered.
- cpu_irq  out  1  DMA-complete interrupt to CPU, level.
- bus_err  out  1  sticky grant-overrun flag.
- grant_cnt  out  CNT_W  cycles BG has been high in the current grant.

## Operation
- FSM states and encoding live in the shared package.
- IDLE: BG=0, cpu_stall=0.
  - BR=1 and cpu_busy=0 → GRANT.
  - BR=1 and cpu_busy=1 → DRAIN.
- DRAIN: BG=0, cpu_stall=1, so no new CPU access may start.
  - Stay while cpu_busy=1.
  - cpu_busy=0 and BR=1 → GRANT.
  - BR=0 → IDLE (request withdrawn).
- GRANT: BG=1, cpu_stall=1, grant_cnt increments each cycle.
  - BR=0 → RELEASE.
  - grant_cnt==MAX_GRANT with BR still 1 → FAULT; bus_err set on the same edge.
- RELEASE: BG=0, cpu_stall=1. This is one dead cycle with the bus undriven. Then → IDLE.
- FAULT: BG=0, cpu_stall=1. Stay until BR=0, then → RELEASE. A new grant is never issued while BR stays high after an overrun.
- grant_cnt:
  - Cleared on entry to GRANT; increments in GRANT, saturating at MAX_GRANT.
  - Holds its value in RELEASE and FAULT; cleared in IDLE.
- bus_err: sticky; cleared only by RST.
- cpu_irq:
  - Set on a rising edge of dma_end, detected against a registered copy of dma_end.
  - Cleared by cpu_irq_ack.
  - An edge and an ack in the same cycle leave it set (set wins).
  - A level held high on dma_end produces one set only.
- An ack with cpu_irq=0 is ignored.
- BR is sampled only on the clock; BR glitches between edges are irrelevant.

## Timing
- Reset values: BG=0, cpu_stall=0, cpu_irq=0, bus_err=0, grant_cnt=0, state=IDLE, dma_end history=0.
- RST is asynchronous. Asserting it mid-grant drops BG and cpu_stall immediately, without waiting for a clock.
- Grant latency:
  - BR rising at edge N with cpu_busy=0 → BG=1 after edge N+1.
  - With cpu_busy high, BG=1 one cycle after the first cycle that samples cpu_busy=0.
- cpu_stall rises no later than BG and falls exactly one cycle after BG falls (the RELEASE cycle).
- BR falling at edge M → BG=0 after edge M+1, cpu_stall=0 after edge M+2.
- cpu_irq rises one cycle after the sampled dma_end rising edge and falls one cycle after cpu_irq_ack.
- Maximum BG high time is MAX_GRANT cycles, so a normal 12-cycle burst completes without a fault.

## Structure
- Shared package dma_pkg holds:
  - state enum: IDLE, DRAIN, GRANT, RELEASE, FAULT;
  - localparam DMA_BURST_WORDS=12;
  - WORD_SIZE=16.
- One sub-module, irq_latch: edge detect plus set/ack latch, reusable for other device interrupts.
- Everything else (FSM and grant counter) is in the top module, with all outputs driven from registers.

## Test plan
- Reset mid-grant: RST pulsed while BG=1 → BG, cpu_stall, grant_cnt go to 0 asynchronously; state IDLE.
- Idle grant: BR=1 with cpu_busy=0 for 12 cycles, then BR=0.
  - BG high for exactly 12 cycles, then 1 dead cycle with cpu_stall=1, then cpu_stall=0.
  - grant_cnt peaks at 12; bus_err stays 0.
- Drain: cpu_busy=1 for 3 cycles when BR rises → BG held 0 during those 3 cycles and rises 1 cycle after cpu_busy falls; cpu_stall=1 throughout.
- Overrun: BR held for 20 cycles → BG drops after 12 cycles, bus_err=1. BG stays 0 until BR falls, then RELEASE, then IDLE; a new BR then grants normally with bus_err still 1.
- Interrupt:
  - dma_end high for 2 cycles → cpu_irq=1 once and stays high until cpu_irq_ack; it falls the cycle after the ack.
  - A new dma_end rising edge in the same cycle as cpu_irq_ack → cpu_irq stays 1.
- Withdrawn request: BR goes high then low while in DRAIN → return to IDLE, BG never asserted, cpu_stall low one cycle after.

Source files
------------

// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types and constants for the DMA bus arbiter.
package dma_pkg;

  // Arbiter FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    GRANT   = 3'd2,
    RELEASE = 3'd3,
    FAULT   = 3'd4
  } dma_state_e;

  // One DMA burst is 12 words of 16 bits
  localparam int DMA_BURST_WORDS = 12;
  localparam int WORD_SIZE       = 16;

  // The CPU is held off in every state except IDLE
  function automatic logic stall_for(input dma_state_e s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/dma_bus_arbiter_irq_latch.sv
// Rising-edge detector plus set/ack level latch for a device interrupt.
// A held-high event input yields one set only; set beats a same-cycle ack.
module irq_latch (
  input  logic clk,
  input  logic rst,
  input  logic evt,
  input  logic ack,
  output logic irq
);

  logic evt_q, evt_d;
  logic irq_q, irq_d;
  logic rise;

  // Edge detect against last cycle's sample; set has priority over ack
  always_comb begin
    rise  = evt & ~evt_q;
    evt_d = evt;
    irq_d = irq_q;
    if (rise)     irq_d = 1'b1;
    else if (ack) irq_d = 1'b0;
  end

  // Event history and interrupt level registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      evt_q <= evt_d;
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: rtl/dma_bus_arbiter.sv
// CPU / DMA bus arbiter: grants the bus to the DMA only when no CPU
// data access is in flight, stalls the CPU while the DMA owns the bus,
// takes the bus back on a grant overrun, and latches the DMA-done IRQ.
module dma_bus_arbiter
  import dma_pkg::*;
#(
  parameter int MAX_GRANT = DMA_BURST_WORDS,
  parameter int CNT_W     = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BR,
  input  logic             dma_end,
  input  logic             cpu_busy,
  input  logic             cpu_irq_ack,
  output logic             BG,
  output logic             cpu_stall,
  output logic             cpu_irq,
  output logic             bus_err,
  output logic [CNT_W-1:0] grant_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_GRANT);

  dma_state_e       state_q, state_d;
  logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             bg_q, bg_d;
  logic             stall_q, stall_d;
  logic             bus_err_q, bus_err_d;

  // Next-state logic. The overrun test uses the count including the
  // current grant cycle, so BG is high for at most MAX_GRANT cycles.
  always_comb begin
    state_d = state_q;
    cnt_inc = (grant_cnt_q == CNT_MAX) ? grant_cnt_q : grant_cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (BR) state_d = cpu_busy ? DRAIN : GRANT;
      end
      DRAIN: begin
        if (!BR)           state_d = IDLE;
        else if (!cpu_busy) state_d = GRANT;
      end
      GRANT: begin
        if (!BR)                  state_d = RELEASE;
        else if (cnt_inc == CNT_MAX) state_d = FAULT;
      end
      RELEASE: state_d = IDLE;
      FAULT: begin
        if (!BR) state_d = RELEASE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant counter, registered outputs and sticky overrun flag
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    case (state_q)
      IDLE, DRAIN: grant_cnt_d = '0;
      GRANT:       grant_cnt_d = cnt_inc;
      default:     grant_cnt_d = grant_cnt_q;
    endcase
    if ((state_d == GRANT) && (state_q != GRANT)) grant_cnt_d = '0;

    bg_d      = (state_d == GRANT);
    stall_d   = stall_for(state_d);
    bus_err_d = bus_err_q | ((state_q == GRANT) && (state_d == FAULT));
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      grant_cnt_q <= '0;
      bg_q        <= 1'b0;
      stall_q     <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_cnt_q <= grant_cnt_d;
      bg_q        <= bg_d;
      stall_q     <= stall_d;
      bus_err_q   <= bus_err_d;
    end
  end

  irq_latch u_dma_irq (
    .clk (CLK),
    .rst (RST),
    .evt (dma_end),
    .ack (cpu_irq_ack),
    .irq (cpu_irq)
  );

  assign BG        = bg_q;
  assign cpu_stall = stall_q;
  assign bus_err   = bus_err_q;
  assign grant_cnt = grant_cnt_q;

endmodule
